vga_pattern_gen: RTL and testbench
==================================

Name: vga_pattern_gen

Overview:
- Stage directly downstream of the VGA sync generator (25 MHz pixel clock, 640x480 in an 800x525 timing frame).
- Consumes raw active-video sync flags and rebuilds column/row counters locked to frame start.
- Generates one of eight 3-bit-per-channel test patterns selected by the board switches.
- Outputs porch-corrected HSync/VSync pulses aligned with the pixel data, ready for the VGA pins.

Parameters:
TOTAL_COLS, 800, pixel clocks per line
TOTAL_ROWS, 525, lines per frame
ACTIVE_COLS, 640, visible pixels per line
ACTIVE_ROWS, 480, visible lines per frame
FRONT_PORCH_H, 18, horizontal front porch in pixels
BACK_PORCH_H, 50, horizontal back porch in pixels
FRONT_PORCH_V, 10, vertical front porch in lines
BACK_PORCH_V, 33, vertical back porch in lines
VIDEO_WIDTH, 3, bits per colour channel

Ports:
i_Clk  input  1  pixel clock; all logic on rising edge
i_Rst  input  1  reset, asynchronous, active-high
i_HSync  input  1  from sync generator; high during active columns
i_VSync  input  1  from sync generator; high during active rows
i_Pattern  input  3  pattern select (switches 1-3)
o_HSync  output  1  porch-corrected horizontal sync, active-low pulse
o_VSync  output  1  porch-corrected vertical sync, active-low pulse
o_Red  output  VIDEO_WIDTH  red channel
o_Grn  output  VIDEO_WIDTH  green channel
o_Blu  output  VIDEO_WIDTH  blue channel
o_Frame_Start  output  1  one-cycle pulse when counters are forced to (0,0)

Behaviour:
- Reset (async, any time, including mid-frame):
  - o_HSync=1, o_VSync=1, RGB=0, o_Frame_Start=0.
  - col=0, row=0, internal frame_valid=0, latched pattern=0.
- Frame start:
  - i_VSync is registered; a rising edge is i_VSync sampled 1 where the previous sample was 0.
  - In the cycle after that edge: col=0, row=0, frame_valid=1, o_Frame_Start=1 for exactly one cycle.
  - i_Pattern is latched at the same time; the pattern is held for the whole frame, so mid-frame switch changes take effect at the next frame start.
- Counters, otherwise each cycle:
  - col increments, wrapping at TOTAL_COLS-1 to 0.
  - row increments when col wraps, and wraps at TOTAL_ROWS-1 to 0.
  - Width: 10 bits each.
  - A frame-start edge arriving off-schedule (resync) overrides the count unconditionally.
- Until frame_valid=1, outputs hold reset values.
- Output stage: registered, one cycle after the counter value it reflects, giving 2 cycles total from the sampled edge to pixel (0,0) on the outputs.
- active = (col < ACTIVE_COLS) && (row < ACTIVE_ROWS). When not active, RGB=0 regardless of pattern.
- o_HSync=0 iff ACTIVE_COLS+FRONT_PORCH_H <= col <= TOTAL_COLS-BACK_PORCH_H-1 (col 658..749), else 1.
- o_VSync=0 iff ACTIVE_ROWS+FRONT_PORCH_V <= row <= TOTAL_ROWS-BACK_PORCH_V-1 (row 490..491), else 1.
- Patterns (max = 7 on all channels of a colour):
  - 0: black.
  - 1: red=7, others 0.
  - 2: green=7, others 0.
  - 3: blue=7, others 0.
  - 4: checkerboard; white if col[5]^row[5], else black (32x32 cells).
  - 5: eight colour bars, ACTIVE_COLS/8 = 80 px wide; bar index b = 0..7 from comparators. R=7 if b[0], G=7 if b[1], B=7 if b[2].
  - 6: 1-pixel white border on col 0, col ACTIVE_COLS-1, row 0 and row ACTIVE_ROWS-1; black elsewhere.
  - 7: gradient; R=col[6:4], G=row[6:4], B=0.
- Simultaneous events:
  - Reset wins over frame start.
  - A frame start coinciding with the natural wrap still yields (0,0) with a single o_Frame_Start pulse.

Test Plan:
- Reset released, i_VSync held 0 for 100 cycles -> o_HSync=o_VSync=1, RGB=0, no o_Frame_Start.
- i_VSync 0->1 sampled at edge k, i_Pattern=1 -> o_Frame_Start=1 at k+1; o_Red=7, o_Grn=0, o_Blu=0 at k+2; RGB=0 at col 640 (cycle k+642).
- Free-run a full frame after sync -> o_HSync low exactly 92 cycles per line starting at col 658; o_VSync low for rows 490-491; counters wrap to (0,0) at cycle 420000 after frame start.
- i_Pattern=5 -> RGB 0/0/0 for col 0-79, 7/0/0 for col 80-159, ..., 7/7/7 for col 560-639.
- i_Pattern changed 1->2 at row 100 -> red for the rest of the frame; green from the next frame start.
- i_Rst pulsed at row 200 -> outputs return to reset values immediately; black until the next i_VSync rising edge, then pattern resumes at (0,0) with 2-cycle latency.

Source files
------------

// File: rtl/vga_pattern_gen.sv
// Test-pattern stage behind the VGA sync generator: rebuilds col/row from frame start, emits RGB and porch-corrected syncs.
// Latency: 2 cycles from the sampled i_VSync rising edge to pixel (0,0) on the outputs; free-running, no backpressure.
module vga_pattern_gen #(
  parameter int TOTAL_COLS    = 800,
  parameter int TOTAL_ROWS    = 525,
  parameter int ACTIVE_COLS   = 640,
  parameter int ACTIVE_ROWS   = 480,
  parameter int FRONT_PORCH_H = 18,
  parameter int BACK_PORCH_H  = 50,
  parameter int FRONT_PORCH_V = 10,
  parameter int BACK_PORCH_V  = 33,
  parameter int VIDEO_WIDTH   = 3
) (
  input  logic                   i_Clk,
  input  logic                   i_Rst,
  input  logic                   i_HSync,
  input  logic                   i_VSync,
  input  logic [2:0]             i_Pattern,
  output logic                   o_HSync,
  output logic                   o_VSync,
  output logic [VIDEO_WIDTH-1:0] o_Red,
  output logic [VIDEO_WIDTH-1:0] o_Grn,
  output logic [VIDEO_WIDTH-1:0] o_Blu,
  output logic                   o_Frame_Start
);

  localparam logic [9:0] C_COL_MAX  = 10'(TOTAL_COLS - 1);
  localparam logic [9:0] C_ROW_MAX  = 10'(TOTAL_ROWS - 1);
  localparam logic [9:0] C_ACT_COLS = 10'(ACTIVE_COLS);
  localparam logic [9:0] C_ACT_ROWS = 10'(ACTIVE_ROWS);
  localparam logic [9:0] C_LAST_COL = 10'(ACTIVE_COLS - 1);
  localparam logic [9:0] C_LAST_ROW = 10'(ACTIVE_ROWS - 1);
  localparam logic [9:0] C_HS_FIRST = 10'(ACTIVE_COLS + FRONT_PORCH_H);
  localparam logic [9:0] C_HS_LAST  = 10'(TOTAL_COLS - BACK_PORCH_H - 1);
  localparam logic [9:0] C_VS_FIRST = 10'(ACTIVE_ROWS + FRONT_PORCH_V);
  localparam logic [9:0] C_VS_LAST  = 10'(TOTAL_ROWS - BACK_PORCH_V - 1);
  localparam int         BAR_W      = ACTIVE_COLS / 8;
  localparam logic [VIDEO_WIDTH-1:0] C_MAX = '1;

  logic                   r_vs_q;
  logic                   r_vs_qq;
  logic [9:0]             r_col;
  logic [9:0]             r_row;
  logic                   r_frame_valid;
  logic [2:0]             r_pattern;
  logic                   w_frame_edge;
  logic                   w_active;
  logic                   w_hs;
  logic                   w_vs;
  logic [2:0]             w_bar;
  logic [VIDEO_WIDTH-1:0] w_red;
  logic [VIDEO_WIDTH-1:0] w_grn;
  logic [VIDEO_WIDTH-1:0] w_blu;
  logic                   w_unused;

  // Horizontal timing is rebuilt locally from frame start, so raw HSync is not needed.
  assign w_unused     = i_HSync;
  assign w_frame_edge = r_vs_q & ~r_vs_qq;

  // Sync history resets high so a VSync already high at reset release is not taken as an edge.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_vs_q        <= 1'b1;
      r_vs_qq       <= 1'b1;
      r_col         <= '0;
      r_row         <= '0;
      r_frame_valid <= 1'b0;
      r_pattern     <= '0;
      o_Frame_Start <= 1'b0;
    end else begin
      r_vs_q        <= i_VSync;
      r_vs_qq       <= r_vs_q;
      o_Frame_Start <= w_frame_edge;
      if (w_frame_edge) begin
        r_col         <= '0;
        r_row         <= '0;
        r_frame_valid <= 1'b1;
        r_pattern     <= i_Pattern;
      end else if (r_col == C_COL_MAX) begin
        r_col <= '0;
        r_row <= (r_row == C_ROW_MAX) ? 10'd0 : r_row + 10'd1;
      end else begin
        r_col <= r_col + 10'd1;
      end
    end
  end

  assign w_active = (r_col < C_ACT_COLS) && (r_row < C_ACT_ROWS);
  assign w_hs     = !((r_col >= C_HS_FIRST) && (r_col <= C_HS_LAST));
  assign w_vs     = !((r_row >= C_VS_FIRST) && (r_row <= C_VS_LAST));

  always_comb begin
    w_bar = '0;
    for (int k = 1; k < 8; k++) begin
      if (r_col >= 10'(k * BAR_W)) w_bar = 3'(k);
    end
  end

  always_comb begin
    w_red = '0;
    w_grn = '0;
    w_blu = '0;
    case (r_pattern)
      3'd1: w_red = C_MAX;
      3'd2: w_grn = C_MAX;
      3'd3: w_blu = C_MAX;
      3'd4: begin
        if (r_col[5] ^ r_row[5]) begin
          w_red = C_MAX;
          w_grn = C_MAX;
          w_blu = C_MAX;
        end
      end
      3'd5: begin
        w_red = w_bar[0] ? C_MAX : '0;
        w_grn = w_bar[1] ? C_MAX : '0;
        w_blu = w_bar[2] ? C_MAX : '0;
      end
      3'd6: begin
        if (r_col == 10'd0 || r_col == C_LAST_COL || r_row == 10'd0 || r_row == C_LAST_ROW) begin
          w_red = C_MAX;
          w_grn = C_MAX;
          w_blu = C_MAX;
        end
      end
      3'd7: begin
        w_red = VIDEO_WIDTH'(r_col[6:4]);
        w_grn = VIDEO_WIDTH'(r_row[6:4]);
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      o_HSync <= 1'b1;
      o_VSync <= 1'b1;
      o_Red   <= '0;
      o_Grn   <= '0;
      o_Blu   <= '0;
    end else if (!r_frame_valid) begin
      o_HSync <= 1'b1;
      o_VSync <= 1'b1;
      o_Red   <= '0;
      o_Grn   <= '0;
      o_Blu   <= '0;
    end else begin
      o_HSync <= w_hs;
      o_VSync <= w_vs;
      o_Red   <= w_active ? w_red : '0;
      o_Grn   <= w_active ? w_grn : '0;
      o_Blu   <= w_active ? w_blu : '0;
    end
  end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Bench for vga_pattern_gen on a shrunken 200x50 frame so several frames fit in a short run.
module tb_vga_pattern_gen;

  localparam int TC    = 200;
  localparam int TR    = 50;
  localparam int AC    = 160;
  localparam int AR    = 40;
  localparam int FPH   = 8;
  localparam int BPH   = 16;
  localparam int FPV   = 3;
  localparam int BPV   = 5;
  localparam int FRAME = TC * TR;

  logic       i_Clk;
  logic       i_Rst;
  logic       i_HSync;
  logic       i_VSync;
  logic [2:0] i_Pattern;
  logic       o_HSync;
  logic       o_VSync;
  logic [2:0] o_Red;
  logic [2:0] o_Grn;
  logic [2:0] o_Blu;
  logic       o_Frame_Start;

  vga_pattern_gen #(
    .TOTAL_COLS(TC), .TOTAL_ROWS(TR), .ACTIVE_COLS(AC), .ACTIVE_ROWS(AR),
    .FRONT_PORCH_H(FPH), .BACK_PORCH_H(BPH), .FRONT_PORCH_V(FPV), .BACK_PORCH_V(BPV),
    .VIDEO_WIDTH(3)
  ) dut (
    .i_Clk(i_Clk), .i_Rst(i_Rst), .i_HSync(i_HSync), .i_VSync(i_VSync),
    .i_Pattern(i_Pattern), .o_HSync(o_HSync), .o_VSync(o_VSync),
    .o_Red(o_Red), .o_Grn(o_Grn), .o_Blu(o_Blu), .o_Frame_Start(o_Frame_Start)
  );

  initial i_Clk = 1'b0;
  always #5 i_Clk = ~i_Clk;

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Model: frame position is elapsed cycles since the forced (0,0), displayed one cycle later.
  int         m_t0   = 0;
  int         m_pend = -1;
  bit         m_valid = 1'b0;
  bit         m_last  = 1'b1;
  logic [2:0] m_pat   = 3'd0;
  bit         ov_valid = 1'b0;
  int         ov_pos   = 0;
  logic [2:0] ov_pat   = 3'd0;
  bit         e_fs     = 1'b0;

  bit sg_en  = 1'b0;
  int sg_pos = 0;
  int sg_k   = 0;
  int k      = 0;

  function automatic logic [10:0] exp_px(input logic [2:0] p, input int c, input int r);
    int red, grn, blu, b;
    bit act, hs, vs;
    red = 0; grn = 0; blu = 0;
    act = (c < AC) && (r < AR);
    hs  = !((c >= AC + FPH) && (c <= TC - BPH - 1));
    vs  = !((r >= AR + FPV) && (r <= TR - BPV - 1));
    case (p)
      3'd1: red = 7;
      3'd2: grn = 7;
      3'd3: blu = 7;
      3'd4: if (((c / 32) + (r / 32)) % 2 == 1) begin red = 7; grn = 7; blu = 7; end
      3'd5: begin
        b   = c / (AC / 8);
        red = (b % 2 == 1) ? 7 : 0;
        grn = ((b / 2) % 2 == 1) ? 7 : 0;
        blu = ((b / 4) % 2 == 1) ? 7 : 0;
      end
      3'd6: if (c == 0 || c == AC - 1 || r == 0 || r == AR - 1) begin red = 7; grn = 7; blu = 7; end
      3'd7: begin red = (c / 16) % 8; grn = (r / 16) % 8; end
      default: ;
    endcase
    if (!act) begin red = 0; grn = 0; blu = 0; end
    return {hs, vs, red[2:0], grn[2:0], blu[2:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge i_Clk) begin
    cyc      = cyc + 1;
    ov_valid = m_valid && !i_Rst;
    ov_pos   = (cyc - 1 - m_t0) % FRAME;
    ov_pat   = m_pat;
    if (i_Rst) begin
      m_valid = 1'b0;
      m_pend  = -1;
      m_last  = 1'b1;
      m_pat   = 3'd0;
      e_fs    = 1'b0;
    end else begin
      e_fs = (m_pend == cyc);
      if (e_fs) begin
        m_t0    = cyc;
        m_valid = 1'b1;
        m_pat   = i_Pattern;
      end
      if (i_VSync && !m_last) m_pend = cyc + 1;
      m_last = i_VSync;
    end
  end

  always @(negedge i_Clk) begin
    logic [10:0] e;
    logic        efs;
    if (i_Rst) begin
      e   = {2'b11, 9'd0};
      efs = 1'b0;
    end else begin
      e   = ov_valid ? exp_px(ov_pat, ov_pos % TC, ov_pos / TC) : {2'b11, 9'd0};
      efs = e_fs;
    end
    chk("pixel{hs,vs,r,g,b}", {o_HSync, o_VSync, o_Red, o_Grn, o_Blu}, 32'(e));
    chk("frame_start", 32'(o_Frame_Start), 32'(efs));
  end

  // Reference sync generator: VSync/HSync high during active rows/columns.
  task automatic tick();
    @(posedge i_Clk);
    #1;
    if (sg_en) begin
      if (sg_pos == 0) sg_k = cyc + 1;
      i_VSync = ((sg_pos / TC) < AR);
      i_HSync = ((sg_pos % TC) < AC);
      sg_pos  = (sg_pos + 1) % FRAME;
    end
  endtask

  task automatic run_to(input int t);
    while (cyc < t) tick();
    @(negedge i_Clk);
  endtask

  task automatic resync();
    sg_pos = FRAME - 2;
    repeat (3) tick();
    k = sg_k;
  endtask

  initial begin
    i_Rst = 1'b1; i_HSync = 1'b0; i_VSync = 1'b0; i_Pattern = 3'd0;
    repeat (3) tick();
    i_Rst = 1'b0;

    run_to(cyc + 100);
    chk("idle_hsync", 32'(o_HSync), 32'd1);
    chk("idle_vsync", 32'(o_VSync), 32'd1);
    chk("idle_red", 32'(o_Red), 32'd0);
    chk("idle_fs", 32'(o_Frame_Start), 32'd0);

    i_Pattern = 3'd1; sg_en = 1'b1; sg_pos = 0;
    tick();
    k = sg_k;
    run_to(k + 1);
    chk("f1_fs_pulse", 32'(o_Frame_Start), 32'd1);
    chk("f1_red_before_px", 32'(o_Red), 32'd0);
    run_to(k + 2);
    chk("f1_px00_red", 32'(o_Red), 32'd7);
    chk("f1_px00_grn", 32'(o_Grn), 32'd0);
    chk("f1_px00_blu", 32'(o_Blu), 32'd0);
    chk("f1_fs_single", 32'(o_Frame_Start), 32'd0);
    run_to(k + 2 + AC);
    chk("f1_col160_red", 32'(o_Red), 32'd0);
    run_to(k + 2 + 167); chk("hs_col167", 32'(o_HSync), 32'd1);
    run_to(k + 2 + 168); chk("hs_col168", 32'(o_HSync), 32'd0);
    run_to(k + 2 + 183); chk("hs_col183", 32'(o_HSync), 32'd0);
    run_to(k + 2 + 184); chk("hs_col184", 32'(o_HSync), 32'd1);
    run_to(k + 2 + 20 * TC);
    i_Pattern = 3'd2;
    run_to(k + 2 + 30 * TC + 10);
    chk("midframe_still_red", 32'(o_Red), 32'd7);
    chk("midframe_no_grn", 32'(o_Grn), 32'd0);
    run_to(k + 2 + 43 * TC - 1); chk("vs_row42", 32'(o_VSync), 32'd1);
    run_to(k + 2 + 43 * TC);     chk("vs_row43", 32'(o_VSync), 32'd0);
    run_to(k + 2 + 45 * TC - 1); chk("vs_row44", 32'(o_VSync), 32'd0);
    run_to(k + 2 + 45 * TC);     chk("vs_row45", 32'(o_VSync), 32'd1);
    run_to(k + FRAME + 1);
    chk("wrap_fs", 32'(o_Frame_Start), 32'd1);
    k = sg_k;
    run_to(k + 2);
    chk("f2_grn", 32'(o_Grn), 32'd7);
    chk("f2_red", 32'(o_Red), 32'd0);

    run_to(k + 1000); i_Pattern = 3'd0; resync();
    run_to(k + 400);  i_Pattern = 3'd5; resync();
    run_to(k + 2 + 25);
    chk("bar1_red", 32'(o_Red), 32'd7);
    chk("bar1_blu", 32'(o_Blu), 32'd0);
    run_to(k + 2 + 139);
    chk("bar6_rgb", 32'({o_Red, o_Grn, o_Blu}), 32'h03f);
    run_to(k + 2 + 140);
    chk("bar7_rgb", 32'({o_Red, o_Grn, o_Blu}), 32'h1ff);
    run_to(k + 600);  i_Pattern = 3'd4; resync();
    run_to(k + 8200); i_Pattern = 3'd7; resync();
    run_to(k + 4000); i_Pattern = 3'd6; resync();
    run_to(k + 9000); i_Pattern = 3'd3;
    run_to(k + FRAME + 1);
    chk("f7_fs", 32'(o_Frame_Start), 32'd1);
    k = sg_k;

    run_to(k + 2 + 20 * TC + 5);
    chk("pre_reset_blu", 32'(o_Blu), 32'd7);
    tick();
    i_Rst = 1'b1; i_Pattern = 3'd1;
    #1;
    chk("async_reset_blu", 32'(o_Blu), 32'd0);
    chk("async_reset_hs", 32'(o_HSync), 32'd1);
    repeat (3) tick();
    i_Rst = 1'b0;
    run_to(k + FRAME + 1);
    chk("resume_fs", 32'(o_Frame_Start), 32'd1);
    chk("resume_black", 32'(o_Red), 32'd0);
    run_to(k + FRAME + 2);
    chk("resume_red", 32'(o_Red), 32'd7);
    chk("resume_grn", 32'(o_Grn), 32'd0);
    run_to(k + FRAME + 500);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
